// File: rtl/fmmu_scan_ctrl_if.sv
// fmmu_scan_ctrl_if: request/acknowledge bus between the FMMU scan sequencer
// and the ESC process-data memory arbiter.
// With FMMU_DIR_EN defined, the bus also carries the access direction (bus_wr).
interface fmmu_scan_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             bus_req;
  logic             bus_ack;
  logic [15:0]      bus_address;
  logic [15:0]      fmmu_map_address_len;
  logic [10:0]      dg_offset;
  logic [IDX_W-1:0] bus_idx;
`ifdef FMMU_DIR_EN
  logic             bus_wr;

  modport master (
    output bus_req, bus_address, fmmu_map_address_len, dg_offset, bus_idx, bus_wr,
    input  bus_ack
  );
  modport slave (
    input  bus_req, bus_address, fmmu_map_address_len, dg_offset, bus_idx, bus_wr,
    output bus_ack
  );
`else
  modport master (
    output bus_req, bus_address, fmmu_map_address_len, dg_offset, bus_idx,
    input  bus_ack
  );
  modport slave (
    input  bus_req, bus_address, fmmu_map_address_len, dg_offset, bus_idx,
    output bus_ack
  );
`endif
endinterface

// File: rtl/fmmu_scan_ctrl.sv
// fmmu_scan_ctrl: scans the FMMU entry table for every logical sub-telegram,
// computes each window intersection and issues one memory request per hit.
// Optional macro FMMU_DIR_EN: per-entry read/write enables and direction check.
module fmmu_scan_ctrl #(
  parameter int N_FMMU = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [31:0]       cfg_log_start,
  input  logic [15:0]       cfg_log_len,
  input  logic [15:0]       cfg_phys_start,
  input  logic              cfg_en,
`ifdef FMMU_DIR_EN
  input  logic              cfg_rd_en,
  input  logic              cfg_wr_en,
  input  logic              sub_rd,
  input  logic              sub_wr,
`endif
  input  logic              sub_valid,
  input  logic [31:0]       sub_address,
  input  logic [10:0]       sub_len,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    hit_cnt,
  fmmu_scan_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      sub_addr_q;
  logic [10:0]      sub_len_q;

  logic [31:0]      ent_log_start  [N_FMMU];
  logic [15:0]      ent_log_len    [N_FMMU];
  logic [15:0]      ent_phys_start [N_FMMU];
  logic             ent_en         [N_FMMU];
`ifdef FMMU_DIR_EN
  logic             ent_rd_en      [N_FMMU];
  logic             ent_wr_en      [N_FMMU];
  logic             sub_rd_q;
  logic             sub_wr_q;
  logic             bus_wr_q;
`endif

  logic             bus_req_q;
  logic [15:0]      bus_address_q;
  logic [15:0]      map_len_q;
  logic [10:0]      dg_offset_q;
  logic [IDX_W-1:0] bus_idx_q;

  logic [32:0]      s_start, s_end, f_start, f_end, lo, hi;
  logic             hit;
  logic             last;
  logic             cfg_ok;

  assign busy   = (state != S_IDLE);
  assign last   = (idx == IDX_W'(N_FMMU - 1));
  assign cfg_ok = cfg_we && (state == S_IDLE) &&
                  ({1'b0, cfg_idx} < (IDX_W + 1)'(N_FMMU));

  assign bus.bus_req              = bus_req_q;
  assign bus.bus_address          = bus_address_q;
  assign bus.fmmu_map_address_len = map_len_q;
  assign bus.dg_offset            = dg_offset_q;
  assign bus.bus_idx              = bus_idx_q;
`ifdef FMMU_DIR_EN
  assign bus.bus_wr               = bus_wr_q;
`endif

  // Window intersection of the latched sub-telegram with the current entry,
  // widened to 33 bits so end addresses never wrap.
  always_comb begin
    s_start = {1'b0, sub_addr_q};
    s_end   = s_start + 33'(sub_len_q);
    f_start = {1'b0, ent_log_start[idx]};
    f_end   = f_start + 33'(ent_log_len[idx]);
    lo      = (s_start > f_start) ? s_start : f_start;
    hi      = (s_end < f_end) ? s_end : f_end;
    hit     = ent_en[idx] && (lo < hi);
`ifdef FMMU_DIR_EN
    hit     = hit && ((sub_rd_q && ent_rd_en[idx]) || (sub_wr_q && ent_wr_en[idx]));
`endif
  end

  // Entry table: cleared by reset, written only while no scan is running.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < N_FMMU; i++) begin
        ent_log_start[i]  <= '0;
        ent_log_len[i]    <= '0;
        ent_phys_start[i] <= '0;
        ent_en[i]         <= 1'b0;
`ifdef FMMU_DIR_EN
        ent_rd_en[i]      <= 1'b0;
        ent_wr_en[i]      <= 1'b0;
`endif
      end
    end else if (cfg_ok) begin
      ent_log_start[cfg_idx]  <= cfg_log_start;
      ent_log_len[cfg_idx]    <= cfg_log_len;
      ent_phys_start[cfg_idx] <= cfg_phys_start;
      ent_en[cfg_idx]         <= cfg_en;
`ifdef FMMU_DIR_EN
      ent_rd_en[cfg_idx]      <= cfg_rd_en;
      ent_wr_en[cfg_idx]      <= cfg_wr_en;
`endif
    end
  end

  // Scan sequencer: one CHECK cycle per entry, holds each request until acked.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state         <= S_IDLE;
      idx           <= '0;
      sub_addr_q    <= '0;
      sub_len_q     <= '0;
      hit_cnt       <= '0;
      done          <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_address_q <= '0;
      map_len_q     <= '0;
      dg_offset_q   <= '0;
      bus_idx_q     <= '0;
`ifdef FMMU_DIR_EN
      sub_rd_q      <= 1'b0;
      sub_wr_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sub_valid) begin
            sub_addr_q <= sub_address;
            sub_len_q  <= sub_len;
`ifdef FMMU_DIR_EN
            sub_rd_q   <= sub_rd;
            sub_wr_q   <= sub_wr;
`endif
            idx        <= '0;
            hit_cnt    <= '0;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            bus_address_q <= ent_phys_start[idx] + 16'(lo - f_start);
            map_len_q     <= 16'(hi - lo);
            dg_offset_q   <= 11'(lo - s_start);
            bus_idx_q     <= idx;
`ifdef FMMU_DIR_EN
            bus_wr_q      <= sub_wr_q;
`endif
            bus_req_q     <= 1'b1;
            hit_cnt       <= hit_cnt + (IDX_W + 1)'(1);
            state         <= S_REQ;
          end else if (last) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_REQ: begin
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_CHECK;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmmu_scan_ctrl.sv
// tb_fmmu_scan_ctrl: directed vectors and hand-written sequences for the FMMU
// scan sequencer (N_FMMU=4).
module tb_fmmu_scan_ctrl;
  localparam int N_FMMU = 4;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              RSTN;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [31:0]       cfg_log_start;
  logic [15:0]       cfg_log_len;
  logic [15:0]       cfg_phys_start;
  logic              cfg_en;
`ifdef FMMU_DIR_EN
  logic              cfg_rd_en, cfg_wr_en, sub_rd, sub_wr;
`endif
  logic              sub_valid;
  logic [31:0]       sub_address;
  logic [10:0]       sub_len;
  logic              busy;
  logic              done;
  logic [IDX_W:0]    hit_cnt;

  fmmu_scan_ctrl_if #(.IDX_W(IDX_W)) bus ();

  fmmu_scan_ctrl #(.N_FMMU(N_FMMU), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .RSTN           (RSTN),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_log_start  (cfg_log_start),
    .cfg_log_len    (cfg_log_len),
    .cfg_phys_start (cfg_phys_start),
    .cfg_en         (cfg_en),
`ifdef FMMU_DIR_EN
    .cfg_rd_en      (cfg_rd_en),
    .cfg_wr_en      (cfg_wr_en),
    .sub_rd         (sub_rd),
    .sub_wr         (sub_wr),
`endif
    .sub_valid      (sub_valid),
    .sub_address    (sub_address),
    .sub_len        (sub_len),
    .busy           (busy),
    .done           (done),
    .hit_cnt        (hit_cnt),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [10:0] l;
    int          exp_n;
    logic [15:0] ea;
    logic [15:0] el;
    logic [10:0] eo;
    logic [1:0]  ei;
    int          exp_lat;
  } vec_t;

  vec_t vt [8];

  int n_vec = 0;
  int n_err = 0;

  // results of the last scan
  int             lat;
  int             nreq;
  logic           got_done;
  logic           done_after;
  logic           stable_bad;
  logic [IDX_W:0] hc;
  logic [15:0]    r_addr [4];
  logic [15:0]    r_len  [4];
  logic [10:0]    r_off  [4];
  logic [1:0]     r_idx  [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] i, input logic [31:0] ls,
                           input logic [15:0] ll, input logic [15:0] ps, input logic e);
    cfg_idx = i; cfg_log_start = ls; cfg_log_len = ll; cfg_phys_start = ps; cfg_en = e;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Starts a scan at the current negedge, acks each request ack_dly cycles
  // after it appears, and records requests, latency and hit count.
  task automatic scan(input logic [31:0] a, input logic [10:0] l, input int ack_dly,
                      input bit poke);
    int wc;
    sub_address = a; sub_len = l; sub_valid = 1'b1;
    @(negedge clk);
    sub_valid = 1'b0; cfg_we = 1'b0;
    lat = 1; nreq = 0; got_done = 1'b0; stable_bad = 1'b0; wc = 0; hc = '0;
    while (!got_done && lat < 200) begin
      bus.bus_ack = 1'b0; sub_valid = 1'b0; cfg_we = 1'b0;
      if (poke && lat == 3) begin
        sub_valid = 1'b1; sub_address = 32'h0000_1004; sub_len = 11'd8;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_log_start = 32'h0000_1000;
        cfg_log_len = 16'h0020; cfg_phys_start = 16'hAAAA; cfg_en = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        hc = hit_cnt;
      end else if (bus.bus_req) begin
        if (wc == 0) begin
          if (nreq < 4) begin
            r_addr[nreq] = bus.bus_address; r_len[nreq] = bus.fmmu_map_address_len;
            r_off[nreq]  = bus.dg_offset;   r_idx[nreq] = bus.bus_idx;
          end
        end else if (nreq < 4) begin
          if (bus.bus_address !== r_addr[nreq] || bus.fmmu_map_address_len !== r_len[nreq] ||
              bus.dg_offset !== r_off[nreq] || bus.bus_idx !== r_idx[nreq])
            stable_bad = 1'b1;
        end
        if (wc == ack_dly) begin
          bus.bus_ack = 1'b1; wc = 0; nreq++;
        end else begin
          wc++;
        end
      end
      if (!got_done) begin
        @(negedge clk);
        lat++;
      end
    end
    bus.bus_ack = 1'b0; sub_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    done_after = done | busy;
  endtask

  initial begin
    int w;
    RSTN = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_log_start = '0; cfg_log_len = '0;
    cfg_phys_start = '0; cfg_en = 1'b0; sub_valid = 1'b0; sub_address = '0; sub_len = '0;
    bus.bus_ack = 1'b0;
`ifdef FMMU_DIR_EN
    cfg_rd_en = 1'b1; cfg_wr_en = 1'b1; sub_rd = 1'b1; sub_wr = 1'b0;
`endif

    vt[0] = '{32'h0000_1004, 11'd8,    1, 16'h1104, 16'h0008, 11'h000, 2'd0, 6};
    vt[1] = '{32'h0000_0FF8, 11'd16,   1, 16'h1100, 16'h0008, 11'h008, 2'd0, 6};
    vt[2] = '{32'h0000_101C, 11'd8,    1, 16'h111C, 16'h0004, 11'h000, 2'd0, 6};
    vt[3] = '{32'h0000_0FF0, 11'h040,  1, 16'h1100, 16'h0020, 11'h010, 2'd0, 6};
    vt[4] = '{32'h0000_0FF8, 11'd8,    0, 16'h0000, 16'h0000, 11'h000, 2'd0, 5};
    vt[5] = '{32'h0000_1004, 11'd0,    0, 16'h0000, 16'h0000, 11'h000, 2'd0, 5};
    vt[6] = '{32'h0000_5000, 11'd8,    0, 16'h0000, 16'h0000, 11'h000, 2'd0, 5};
    vt[7] = '{32'h0000_1020, 11'd4,    0, 16'h0000, 16'h0000, 11'h000, 2'd0, 5};

    repeat (2) @(negedge clk);
    RSTN = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus.bus_req, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_addr", bus.bus_address, 0);
    chk("rst_len", bus.fmmu_map_address_len, 0);
    chk("rst_off", bus.dg_offset, 0);
    chk("rst_idx", bus.bus_idx, 0);

    cfg_write(2'd0, 32'h0000_1000, 16'h0020, 16'h1100, 1'b1);
    cfg_write(2'd1, 32'h0000_5000, 16'h0010, 16'h2000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      scan(vt[i].a, vt[i].l, 0, 1'b0);
      chk($sformatf("v%0d_done", i), got_done, 1);
      chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_nreq", i), nreq, vt[i].exp_n);
      chk($sformatf("v%0d_hit_cnt", i), hc, vt[i].exp_n);
      chk($sformatf("v%0d_done_pulse", i), done_after, 0);
      if (vt[i].exp_n == 1) begin
        chk($sformatf("v%0d_addr", i), r_addr[0], vt[i].ea);
        chk($sformatf("v%0d_len", i), r_len[0], vt[i].el);
        chk($sformatf("v%0d_off", i), r_off[0], vt[i].eo);
        chk($sformatf("v%0d_idx", i), r_idx[0], vt[i].ei);
      end
    end

    // simultaneous config write and start: the scan sees the new entry
    cfg_idx = 2'd1; cfg_log_start = 32'h0000_6000; cfg_log_len = 16'h0010;
    cfg_phys_start = 16'h4000; cfg_en = 1'b1; cfg_we = 1'b1;
    scan(32'h0000_6000, 11'd4, 0, 1'b0);
    chk("sim_nreq", nreq, 1);
    chk("sim_addr", r_addr[0], 16'h4000);
    chk("sim_len", r_len[0], 16'h0004);
    chk("sim_idx", r_idx[0], 2'd1);

    // two hits with ack stalls, sub_valid and cfg_we poked mid-scan
    cfg_write(2'd2, 32'h0000_1010, 16'h0020, 16'h3000, 1'b1);
    scan(32'h0000_1000, 11'h040, 3, 1'b1);
    chk("two_done", got_done, 1);
    chk("two_nreq", nreq, 2);
    chk("two_idx0", r_idx[0], 2'd0);
    chk("two_addr0", r_addr[0], 16'h1100);
    chk("two_len0", r_len[0], 16'h0020);
    chk("two_off0", r_off[0], 11'h000);
    chk("two_idx1", r_idx[1], 2'd2);
    chk("two_addr1", r_addr[1], 16'h3000);
    chk("two_len1", r_len[1], 16'h0020);
    chk("two_off1", r_off[1], 11'h010);
    chk("two_stable", stable_bad, 0);
    chk("two_hit_cnt", hc, 2);
    chk("two_lat", lat, 13);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("no_rescan_%0d", i), busy, 0);
      @(negedge clk);
    end
    chk("hit_cnt_hold", hit_cnt, 2);

    // the write issued during the scan was dropped
    scan(32'h0000_1004, 11'd8, 0, 1'b0);
    chk("busy_cfg_nreq", nreq, 1);
    chk("busy_cfg_addr", r_addr[0], 16'h1104);

    // physical address wraps modulo 2^16
    cfg_write(2'd3, 32'h0000_2000, 16'h0040, 16'hFFF0, 1'b1);
    scan(32'h0000_2020, 11'd8, 0, 1'b0);
    chk("wrap_nreq", nreq, 1);
    chk("wrap_addr", r_addr[0], 16'h0010);
    chk("wrap_len", r_len[0], 16'h0008);
    chk("wrap_idx", r_idx[0], 2'd3);
    chk("wrap_lat", lat, 6);

    // reset while a request is pending
    sub_address = 32'h0000_1004; sub_len = 11'd8; sub_valid = 1'b1;
    @(negedge clk);
    sub_valid = 1'b0;
    w = 0;
    while (!bus.bus_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_req_seen", bus.bus_req, 1);
    #2 RSTN = 1'b0;
    #1;
    chk("rst_mid_req", bus.bus_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    RSTN = 1'b1;
    @(negedge clk);
    scan(32'h0000_1004, 11'd8, 0, 1'b0);
    chk("post_rst_nreq", nreq, 0);
    chk("post_rst_hit_cnt", hc, 0);
    chk("post_rst_lat", lat, 5);
    scan(32'h0000_2020, 11'd8, 0, 1'b0);
    chk("post_rst_nreq3", nreq, 0);

`ifdef FMMU_DIR_EN
    cfg_rd_en = 1'b0; cfg_wr_en = 1'b1;
    cfg_write(2'd0, 32'h0000_1000, 16'h0020, 16'h1100, 1'b1);
    sub_rd = 1'b1; sub_wr = 1'b0;
    scan(32'h0000_1004, 11'd8, 0, 1'b0);
    chk("dir_rd_on_wr_nreq", nreq, 0);
    sub_rd = 1'b0; sub_wr = 1'b1;
    scan(32'h0000_1004, 11'd8, 0, 1'b0);
    chk("dir_wr_on_wr_nreq", nreq, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
